// File: rtl/dac_control.sv
// Serial DAC transmitter: EBI register writes feed a small frame FIFO; frames are shifted
// MSB-first on dac_sclk/dac_din framed by dac_cs_n, optionally held until a start time.
// Optional feature macro: DAC_LDAC_EN (adds the LDAC pulse state after each frame).
module dac_control #(
  parameter int unsigned MIN_CHANNEL     = 0,
  parameter int unsigned MAX_CHANNEL     = 1,
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] data_in_i,
  input  logic        enable_i,
  input  logic        re_i,
  input  logic        wr_i,
  output logic [15:0] data_out_o,
  input  logic [31:0] current_time_i,
  output logic        dac_sclk_o,
  output logic        dac_cs_n_o,
  output logic        dac_din_o,
  output logic        dac_ldac_n_o,
  output logic        busy_o
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW  = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StLdac} state_e;

  state_e                     state_q, state_d;
  logic [DivW-1:0]            div_q, div_d;
  logic                       phase_q, phase_d;
  logic [3:0]                 bitcnt_q, bitcnt_d;
  logic [15:0]                shreg_q, shreg_d;
  logic [15:0]                frame_q, frame_d;
  logic [15:0]                last_q, last_d;
  logic                       ovf_q, ovf_d;
  logic [31:0]                start_time_q;
  logic [15:0]                data_out_q, data_out_d;
  logic [15:0]                mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]            count_q;

  // Channel decode without a borrow-prone unsigned compare against MIN_CHANNEL.
  logic [8:0]  ch_off;
  logic        sel;
  logic [2:0]  ch;
  logic [3:0]  reg_sel;
  assign ch_off  = {1'b0, addr_i[15:8]} - 9'(MIN_CHANNEL);
  assign sel     = enable_i && !ch_off[8] && (ch_off <= 9'(MAX_CHANNEL - MIN_CHANNEL));
  assign ch      = ch_off[2:0];
  assign reg_sel = addr_i[3:0];

  logic        empty, full, time_ok, pop, push_req, push, ovf_set, ovf_rd, ht;
  logic [15:0] push_data;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(Depth));
  assign time_ok   = (start_time_q == '0) || (current_time_i >= start_time_q);
  assign pop       = (state_q == StIdle) && !empty && time_ok;
  assign push_req  = sel && wr_i && ((reg_sel == 4'h4) || (reg_sel == 4'h5));
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && !push;
  assign ovf_rd    = sel && re_i && (reg_sel == 4'hE);
  assign push_data = (reg_sel == 4'h5) ? {1'b0, ch, data_in_i[11:0]} : data_in_i[15:0];
  assign ht        = (div_q == DivW'(CLK_DIV - 1));
  assign ovf_d     = ovf_set || (ovf_q && !ovf_rd);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  // FIFO pointers, fill count and status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      start_time_q <= '0;
      data_out_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      if (sel && wr_i && (reg_sel == 4'h6)) start_time_q <= data_in_i;
    end
  end

  // Register read mux; data_out returns to zero on any cycle without a read.
  always_comb begin
    data_out_d = '0;
    if (sel && re_i) begin
      case (reg_sel)
        4'h9:    data_out_d = 16'h0DAC;
        4'hA:    data_out_d = {15'h0, busy_o};
        4'hB:    data_out_d = last_q;
        4'hD:    data_out_d = 16'(count_q);
        4'hE:    data_out_d = {15'h0, ovf_q};
        default: data_out_d = '0;
      endcase
    end
  end

  // Transmit FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      frame_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      frame_q  <= frame_d;
      last_q   <= last_d;
    end
  end

  // Next-state logic; phase_q doubles as the 2-half-tick counter in GAP and LDAC.
  always_comb begin
    state_d  = state_q;
    div_d    = ht ? '0 : div_q + 1'b1;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    frame_d  = frame_q;
    last_d   = last_q;
    case (state_q)
      StIdle: begin
        div_d = '0;
        if (pop) begin
          state_d  = StLoad;
          shreg_d  = mem_q[rptr_q];
          frame_d  = mem_q[rptr_q];
          phase_d  = 1'b0;
          bitcnt_d = '0;
        end
      end
      StLoad: begin
        if (ht) state_d = StShift;
      end
      StShift: begin
        if (ht) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            shreg_d  = {shreg_q[14:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 4'd15) begin
              state_d = StGap;
              last_d  = frame_q;
            end
          end
        end
      end
      StGap: begin
        if (ht) begin
          phase_d = ~phase_q;
`ifdef DAC_LDAC_EN
          if (phase_q) state_d = StLdac;
`else
          if (phase_q) state_d = StIdle;
`endif
        end
      end
      StLdac: begin
        if (ht) begin
          phase_d = ~phase_q;
          if (phase_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serial outputs decoded from registered state.
  always_comb begin
    dac_cs_n_o = !((state_q == StLoad) || (state_q == StShift));
    dac_sclk_o = (state_q == StShift) ? phase_q : 1'b1;
    dac_din_o  = dac_cs_n_o ? 1'b0 : shreg_q[15];
`ifdef DAC_LDAC_EN
    dac_ldac_n_o = (state_q != StLdac);
`else
    dac_ldac_n_o = 1'b0;
`endif
  end

  assign busy_o     = !empty || (state_q != StIdle);
  assign data_out_o = data_out_q;

endmodule

// File: tb/tb_dac_control.sv
// Directed self-checking bench for dac_control (CLK_DIV=4, FIFO depth 4).
module tb_dac_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic [31:0] data_in = '0;
  logic        enable = 1'b0, re = 1'b0, wr = 1'b0;
  logic [31:0] current_time = '0;
  logic [15:0] data_out;
  logic        dac_sclk, dac_cs_n, dac_din, dac_ldac_n, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dac_control #(
    .MIN_CHANNEL(0), .MAX_CHANNEL(1), .CLK_DIV(4), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_in_i(data_in), .enable_i(enable),
    .re_i(re), .wr_i(wr), .data_out_o(data_out), .current_time_i(current_time),
    .dac_sclk_o(dac_sclk), .dac_cs_n_o(dac_cs_n), .dac_din_o(dac_din),
    .dac_ldac_n_o(dac_ldac_n), .busy_o(busy)
  );

  // Serial receiver model: samples din on each rising sclk while selected.
  logic [15:0] rx_shift = '0;
  int          rx_bits = 0;
  int          last_bits = 0;
  int          sclk_edges = 0;
  logic [15:0] frames [64];
  int          frame_cnt = 0;

  always @(posedge dac_sclk) begin
    sclk_edges++;
    if (dac_cs_n === 1'b0) begin
      rx_shift = {rx_shift[14:0], dac_din};
      rx_bits++;
    end
  end
  always @(negedge dac_cs_n) rx_bits = 0;
  always @(posedge dac_cs_n) begin
    last_bits = rx_bits;
    if (rx_bits == 16) begin
      frames[frame_cnt & 63] = rx_shift;
      frame_cnt++;
    end
    rx_bits = 0;
  end

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data_in = d; enable = 1'b1; wr = 1'b1;
    @(negedge clk);
    enable = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; enable = 1'b1; re = 1'b1;
    @(negedge clk);
    enable = 1'b0; re = 1'b0;
    d = data_out;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n); n_fail++;
    end
  endtask

  task automatic wait_frames(input int target, input int bound);
    int n = 0;
    while (frame_cnt < target && n < bound) begin @(negedge clk); n++; end
    n_tests++;
    if (frame_cnt != target) begin
      $display("FAIL wait_frames: frame_cnt=%0d required %0d", frame_cnt, target); n_fail++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        exp_ldac;
`ifdef DAC_LDAC_EN
    exp_ldac = 1'b1;
`else
    exp_ldac = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({dac_cs_n, dac_sclk, dac_din, busy, data_out} !== {4'b1100, 16'h0}) begin
      $display("FAIL reset_pins: cs_n/sclk/din/busy/dout=%b%b%b%b/%h required 1100/0000",
               dac_cs_n, dac_sclk, dac_din, busy, data_out); n_fail++;
    end
    n_tests++;
    if (dac_ldac_n !== exp_ldac) begin
      $display("FAIL reset_ldac: got %b required %b", dac_ldac_n, exp_ldac); n_fail++;
    end
    bus_read(16'h0009, d); n_tests++;
    if (d !== 16'h0DAC) begin $display("FAIL id: got %h required 0dac", d); n_fail++; end
    bus_read(16'h010D, d); n_tests++;
    if (d !== 16'h0) begin $display("FAIL reset_level: got %h required 0", d); n_fail++; end
    bus_read(16'h000B, d); n_tests++;
    if (d !== 16'h0) begin $display("FAIL reset_last: got %h required 0", d); n_fail++; end
    bus_read(16'h000E, d); n_tests++;
    if (d !== 16'h0) begin $display("FAIL reset_ovf: got %h required 0", d); n_fail++; end
    bus_read(16'h0209, d); n_tests++;
    if (d !== 16'h0) begin $display("FAIL bad_chan_read: got %h required 0", d); n_fail++; end
    bus_read(16'h0007, d); n_tests++;
    if (d !== 16'h0) begin $display("FAIL bad_reg_read: got %h required 0", d); n_fail++; end
    bus_write(16'h0204, 32'h1234);
    @(negedge clk); n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL bad_chan_write: busy=%b required 0", busy); n_fail++;
    end
  endtask

  task automatic test_program();
    logic [15:0] d;
    int waited = 0, low = 0, ldac_low = 0, first_low = -1;
    int exp_low, exp_first;
    bus_write(16'h0004, 32'h0000A5C3);
    while (dac_cs_n !== 1'b0 && waited < 10) begin @(negedge clk); waited++; end
    n_tests++;
    if (waited < 1 || waited > 2) begin
      $display("FAIL cs_latency: got %0d clk required 1..2", waited); n_fail++;
    end
    while (dac_cs_n === 1'b0 && low < 300) begin @(negedge clk); low++; end
    n_tests++;
    if (low != 132) begin $display("FAIL cs_low_len: got %0d required 132", low); n_fail++; end
    for (int i = 0; i < 20; i++) begin
      if (dac_ldac_n === 1'b0) begin
        ldac_low++;
        if (first_low < 0) first_low = i;
      end
      @(negedge clk);
    end
`ifdef DAC_LDAC_EN
    exp_low = 8; exp_first = 8;
`else
    exp_low = 20; exp_first = 0;
`endif
    n_tests++;
    if (ldac_low != exp_low || first_low != exp_first) begin
      $display("FAIL ldac: low=%0d start=%0d required low=%0d start=%0d",
               ldac_low, first_low, exp_low, exp_first); n_fail++;
    end
    n_tests++;
    if (frame_cnt != 1 || frames[0] !== 16'hA5C3 || last_bits != 16) begin
      $display("FAIL program_frame: cnt=%0d data=%h bits=%0d required 1/a5c3/16",
               frame_cnt, frames[0], last_bits); n_fail++;
    end
    wait_idle(100);
    bus_read(16'h000B, d); n_tests++;
    if (d !== 16'hA5C3) begin $display("FAIL last: got %h required a5c3", d); n_fail++; end
  endtask

  task automatic test_value();
    int base = frame_cnt;
    bus_write(16'h0105, 32'h00000123);
    wait_frames(base + 1, 300);
    n_tests++;
    if (frames[base & 63] !== 16'h1123) begin
      $display("FAIL value_frame: got %h required 1123", frames[base & 63]); n_fail++;
    end
    wait_idle(100);
  endtask

  task automatic test_start();
    int base = frame_cnt;
    int bad = 0;
    current_time = 32'd900;
    bus_write(16'h0006, 32'd1000);
    bus_write(16'h0004, 32'h000000FF);
    while (current_time < 32'd1000) begin
      @(negedge clk);
      if (dac_cs_n !== 1'b1 || busy !== 1'b1) bad++;
      current_time = current_time + 1;
    end
    n_tests++;
    if (bad != 0) begin $display("FAIL start_wait: %0d bad cycles required 0", bad); n_fail++; end
    @(negedge clk); n_tests++;
    if (dac_cs_n !== 1'b0) begin
      $display("FAIL start_go: cs_n=%b required 0", dac_cs_n); n_fail++;
    end
    wait_frames(base + 1, 300);
    n_tests++;
    if (frames[base & 63] !== 16'h00FF) begin
      $display("FAIL start_frame: got %h required 00ff", frames[base & 63]); n_fail++;
    end
    wait_idle(100);
    bus_write(16'h0006, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int base = frame_cnt;
    int bad = 0;
    for (int i = 0; i < 5; i++) bus_write(16'h0004, 32'h1000 + i);
    bus_read(16'h000D, d); n_tests++;
    if (d !== 16'd4) begin $display("FAIL b2b_level: got %h required 4", d); n_fail++; end
    bus_read(16'h000E, d); n_tests++;
    if (d !== 16'd0) begin $display("FAIL b2b_ovf5: got %h required 0", d); n_fail++; end
    wait_frames(base + 5, 900);
    for (int i = 0; i < 5; i++) if (frames[(base + i) & 63] !== 16'(16'h1000 + i)) bad++;
    n_tests++;
    if (bad != 0) begin $display("FAIL b2b_data5: %0d wrong frames required 0", bad); n_fail++; end
    wait_idle(100);
    base = frame_cnt; bad = 0;
    for (int i = 0; i < 6; i++) bus_write(16'h0004, 32'h2000 + i);
    bus_read(16'h000E, d); n_tests++;
    if (d !== 16'd1) begin $display("FAIL b2b_ovf6: got %h required 1", d); n_fail++; end
    bus_read(16'h000E, d); n_tests++;
    if (d !== 16'd0) begin $display("FAIL ovf_clear: got %h required 0", d); n_fail++; end
    wait_frames(base + 5, 900);
    wait_idle(200);
    repeat (50) @(negedge clk);
    n_tests++;
    if (frame_cnt != base + 5) begin
      $display("FAIL b2b_count6: got %0d frames required 5", frame_cnt - base); n_fail++;
    end
    for (int i = 0; i < 5; i++) if (frames[(base + i) & 63] !== 16'(16'h2000 + i)) bad++;
    n_tests++;
    if (bad != 0) begin $display("FAIL b2b_data6: %0d wrong frames required 0", bad); n_fail++; end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] d;
    int base = frame_cnt;
    int n = 0, edges0;
    bus_write(16'h0004, 32'hFFFF);
    bus_write(16'h0004, 32'h0F0F);
    while (rx_bits < 8 && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (rx_bits < 8) begin $display("FAIL mid_reach: bits=%0d required 8", rx_bits); n_fail++; end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({dac_cs_n, dac_sclk, dac_din} !== 3'b110) begin
      $display("FAIL mid_reset_pins: cs_n/sclk/din=%b%b%b required 110",
               dac_cs_n, dac_sclk, dac_din); n_fail++;
    end
    reset = 1'b0;
    edges0 = sclk_edges;
    repeat (300) @(negedge clk);
    n_tests++;
    if (sclk_edges != edges0 || frame_cnt != base || busy !== 1'b0) begin
      $display("FAIL mid_quiet: edges=%0d frames=%0d busy=%b required 0/0/0",
               sclk_edges - edges0, frame_cnt - base, busy); n_fail++;
    end
    bus_read(16'h000D, d); n_tests++;
    if (d !== 16'd0) begin $display("FAIL mid_level: got %h required 0", d); n_fail++; end
    bus_read(16'h000B, d); n_tests++;
    if (d !== 16'd0) begin $display("FAIL mid_last: got %h required 0", d); n_fail++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_value();
    test_start();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
